// File: rtl/wb_regfile_pkg.sv
// Shared types and sizing for the writeback register file and its
// pending-write scoreboard.
package wb_regfile_pkg;

    localparam int unsigned XLEN   = 64;
    localparam int unsigned NREG   = 32;
    localparam int unsigned RIDX_W = $clog2(NREG);
    localparam int unsigned PEND_W = 2;
    localparam int unsigned CNT_W  = 64;

    typedef logic [XLEN-1:0]   xdata_t;
    typedef logic [RIDX_W-1:0] ridx_t;
    typedef logic [PEND_W-1:0] pend_t;
    typedef logic [CNT_W-1:0]  wcnt_t;

    localparam pend_t PEND_MAX = '1;

    typedef enum logic [1:0] {
        PEND_HOLD = 2'd0,
        PEND_INC  = 2'd1,
        PEND_DEC  = 2'd2
    } pend_op_e;

    // Reserve and retire on the same register in one cycle cancel out.
    function automatic pend_op_e pend_op(input logic inc, input logic dec);
        pend_op_e op;
        op = PEND_HOLD;
        if (inc && !dec) begin
            op = PEND_INC;
        end else if (dec && !inc) begin
            op = PEND_DEC;
        end
        return op;
    endfunction

endpackage

// File: rtl/wb_regfile_if.sv
// Decode/issue/writeback-facing signal bundle of the register file.
interface wb_regfile_if;
    import wb_regfile_pkg::*;

    ridx_t  i_rd;
    logic   i_rd_wen;
    xdata_t i_rd_wdata;
    ridx_t  i_rs1;
    ridx_t  i_rs2;
    xdata_t o_rs1_data;
    xdata_t o_rs2_data;
    logic   o_rs1_busy;
    logic   o_rs2_busy;
    logic   i_issue_valid;
    ridx_t  i_issue_rd;
    logic   o_issue_ready;
    wcnt_t  o_wr_cnt;

    modport master (
        output i_rd, i_rd_wen, i_rd_wdata,
        output i_rs1, i_rs2,
        input  o_rs1_data, o_rs2_data, o_rs1_busy, o_rs2_busy,
        output i_issue_valid, i_issue_rd,
        input  o_issue_ready,
        input  o_wr_cnt
    );

    modport slave (
        input  i_rd, i_rd_wen, i_rd_wdata,
        input  i_rs1, i_rs2,
        output o_rs1_data, o_rs2_data, o_rs1_busy, o_rs2_busy,
        input  i_issue_valid, i_issue_rd,
        output o_issue_ready,
        output o_wr_cnt
    );

endinterface

// File: rtl/wb_regfile_scoreboard.sv
// Per-register pending-write counters: reserved at issue, retired at writeback.
// Produces operand busy flags and issue back-pressure.
module wb_scoreboard
    import wb_regfile_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  ridx_t wb_rd_i,
    input  logic  wb_wen_i,
    input  logic  issue_valid_i,
    input  ridx_t issue_rd_i,
    input  ridx_t rs1_i,
    input  ridx_t rs2_i,
    output logic  rs1_busy_o,
    output logic  rs2_busy_o,
    output logic  issue_ready_o
);

    pend_t           pend_q  [NREG];
    pend_t           pend_d  [NREG];
    pend_t           pend_wb [NREG];
    logic [NREG-1:0] inc_v;
    logic [NREG-1:0] dec_v;

    // Ready looks only at the registered count so WB never feeds issue combinationally.
    always_comb begin
        issue_ready_o = (issue_rd_i == '0) || (pend_q[issue_rd_i] != PEND_MAX);
    end

    always_comb begin
        inc_v = '0;
        dec_v = '0;
        for (int unsigned r = 1; r < NREG; r++) begin
            inc_v[r] = issue_valid_i && issue_ready_o && (issue_rd_i == ridx_t'(r));
            dec_v[r] = wb_wen_i && (wb_rd_i == ridx_t'(r)) && (pend_q[r] != '0);
        end
    end

    always_comb begin
        for (int unsigned r = 0; r < NREG; r++) begin
            pend_wb[r] = pend_q[r] - pend_t'(dec_v[r]);
            pend_d[r]  = pend_q[r];
            unique case (pend_op(inc_v[r], dec_v[r]))
                PEND_INC: pend_d[r] = pend_q[r] + pend_t'(1);
                PEND_DEC: pend_d[r] = pend_q[r] - pend_t'(1);
                default:  pend_d[r] = pend_q[r];
            endcase
        end
    end

    // Busy sees this cycle's retirement but not this cycle's reservation.
    always_comb begin
        rs1_busy_o = (rs1_i != '0) && (pend_wb[rs1_i] != '0);
        rs2_busy_o = (rs2_i != '0) && (pend_wb[rs2_i] != '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned r = 0; r < NREG; r++) begin
                pend_q[r] <= '0;
            end
        end else begin
            pend_q[0] <= '0;
            for (int unsigned r = 1; r < NREG; r++) begin
                pend_q[r] <= pend_d[r];
            end
        end
    end

endmodule

// File: rtl/wb_regfile.sv
// 32 x 64-bit integer register file fed by writeback, with same-cycle read
// bypass, committed-write counter and a RAW-hazard scoreboard.
module wb_regfile
    import wb_regfile_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    wb_regfile_if.slave  bus
);

    xdata_t regs_q [NREG];
    wcnt_t  wr_cnt_q;
    wcnt_t  wr_cnt_d;
    logic   wr_en;

    assign wr_en    = bus.i_rd_wen && (bus.i_rd != '0);
    assign wr_cnt_d = wr_cnt_q + wcnt_t'(wr_en);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned r = 0; r < NREG; r++) begin
                regs_q[r] <= '0;
            end
            wr_cnt_q <= '0;
        end else begin
            if (wr_en) begin
                regs_q[bus.i_rd] <= bus.i_rd_wdata;
            end
            wr_cnt_q <= wr_cnt_d;
        end
    end

    always_comb begin
        bus.o_rs1_data = '0;
        if (bus.i_rs1 != '0) begin
            if (bus.i_rd_wen && (bus.i_rd == bus.i_rs1)) begin
                bus.o_rs1_data = bus.i_rd_wdata;
            end else begin
                bus.o_rs1_data = regs_q[bus.i_rs1];
            end
        end
    end

    always_comb begin
        bus.o_rs2_data = '0;
        if (bus.i_rs2 != '0) begin
            if (bus.i_rd_wen && (bus.i_rd == bus.i_rs2)) begin
                bus.o_rs2_data = bus.i_rd_wdata;
            end else begin
                bus.o_rs2_data = regs_q[bus.i_rs2];
            end
        end
    end

    assign bus.o_wr_cnt = wr_cnt_q;

    wb_scoreboard u_scoreboard (
        .clk           (clk),
        .rst           (rst),
        .wb_rd_i       (bus.i_rd),
        .wb_wen_i      (bus.i_rd_wen),
        .issue_valid_i (bus.i_issue_valid),
        .issue_rd_i    (bus.i_issue_rd),
        .rs1_i         (bus.i_rs1),
        .rs2_i         (bus.i_rs2),
        .rs1_busy_o    (bus.o_rs1_busy),
        .rs2_busy_o    (bus.o_rs2_busy),
        .issue_ready_o (bus.o_issue_ready)
    );

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed scenarios plus randomized
// traffic compared against an array/counter reference model.
module tb_wb_regfile;
    import wb_regfile_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    wb_regfile_if bus ();

    wb_regfile u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [63:0] m_reg [32];
    int          m_pend [32];
    logic [63:0] m_cnt;

    function automatic void m_clear();
        for (int i = 0; i < 32; i++) begin
            m_reg[i]  = '0;
            m_pend[i] = 0;
        end
        m_cnt = '0;
    endfunction

    function automatic logic [63:0] m_data(input logic [4:0] rs);
        if (rs == 0) return '0;
        if (bus.i_rd_wen && bus.i_rd == rs) return bus.i_rd_wdata;
        return m_reg[rs];
    endfunction

    function automatic logic m_busy(input logic [4:0] rs);
        int p;
        if (rs == 0) return 1'b0;
        p = m_pend[rs];
        if (bus.i_rd_wen && bus.i_rd == rs && p > 0) p = p - 1;
        return (p != 0);
    endfunction

    function automatic logic m_ready();
        return (bus.i_issue_rd == 0) || (m_pend[bus.i_issue_rd] < 3);
    endfunction

    task automatic idle();
        bus.i_rd_wen      = 1'b0;
        bus.i_rd          = '0;
        bus.i_rd_wdata    = '0;
        bus.i_issue_valid = 1'b0;
        bus.i_issue_rd    = '0;
    endtask

    // Advance one clock; the model commits the inputs present before the edge.
    task automatic step();
        logic        rdy;
        logic        wen;
        logic [4:0]  rd;
        logic [63:0] wd;
        logic        iv;
        logic [4:0]  ird;
        rdy = m_ready();
        wen = bus.i_rd_wen;  rd = bus.i_rd;  wd = bus.i_rd_wdata;
        iv  = bus.i_issue_valid;  ird = bus.i_issue_rd;
        @(posedge clk);
        if (wen && rd != 0) begin
            m_reg[rd] = wd;
            m_cnt     = m_cnt + 64'd1;
            if (m_pend[rd] > 0) m_pend[rd] = m_pend[rd] - 1;
        end
        if (iv && rdy && ird != 0) m_pend[ird] = m_pend[ird] + 1;
        @(negedge clk);
    endtask

    task automatic rand_inputs();
        bus.i_rd          = 5'($urandom_range(0, 7));
        bus.i_rd_wen      = 1'($urandom_range(0, 1));
        bus.i_rd_wdata    = {$urandom, $urandom};
        bus.i_rs1         = 5'($urandom_range(0, 7));
        bus.i_rs2         = 5'($urandom_range(0, 7));
        bus.i_issue_valid = 1'($urandom_range(0, 1));
        bus.i_issue_rd    = 5'($urandom_range(0, 7));
    endtask

    task automatic test_reset();
        for (int i = 0; i < 20; i++) begin
            rand_inputs();
            step();
        end
        #2;
        idle();
        bus.i_rs1      = 5'($urandom_range(1, 7));
        bus.i_rs2      = 5'($urandom_range(1, 7));
        bus.i_issue_rd = 5'($urandom_range(1, 7));
        rst = 1'b0;
        #1;
        m_clear();
        checks++;
        if (bus.o_rs1_data !== 64'd0) begin
            failures++; $display("FAIL reset_rs1_data: got %h expected 0", bus.o_rs1_data);
        end
        checks++;
        if (bus.o_rs2_data !== 64'd0) begin
            failures++; $display("FAIL reset_rs2_data: got %h expected 0", bus.o_rs2_data);
        end
        checks++;
        if (bus.o_rs1_busy !== 1'b0 || bus.o_rs2_busy !== 1'b0) begin
            failures++; $display("FAIL reset_busy: got %b%b expected 00", bus.o_rs1_busy, bus.o_rs2_busy);
        end
        checks++;
        if (bus.o_issue_ready !== 1'b1) begin
            failures++; $display("FAIL reset_issue_ready: got %b expected 1", bus.o_issue_ready);
        end
        checks++;
        if (bus.o_wr_cnt !== 64'd0) begin
            failures++; $display("FAIL reset_wr_cnt: got %0d expected 0", bus.o_wr_cnt);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_bypass();
        logic [63:0] wd;
        wd = 64'hDEAD_BEEF_0000_0001;
        idle();
        bus.i_rd = 5'd5;  bus.i_rd_wen = 1'b1;  bus.i_rd_wdata = wd;  bus.i_rs1 = 5'd5;
        #1;
        checks++;
        if (bus.o_rs1_data !== wd) begin
            failures++; $display("FAIL bypass_same_cycle: got %h expected %h", bus.o_rs1_data, wd);
        end
        step();
        idle();
        #1;
        checks++;
        if (bus.o_rs1_data !== wd) begin
            failures++; $display("FAIL bypass_next_cycle: got %h expected %h", bus.o_rs1_data, wd);
        end
        checks++;
        if (bus.o_wr_cnt !== 64'd1) begin
            failures++; $display("FAIL bypass_wr_cnt: got %0d expected 1", bus.o_wr_cnt);
        end
    endtask

    task automatic test_x0();
        logic [63:0] cnt0;
        cnt0 = m_cnt;
        idle();
        bus.i_rd = 5'd0;  bus.i_rd_wen = 1'b1;  bus.i_rd_wdata = '1;  bus.i_rs2 = 5'd0;
        #1;
        checks++;
        if (bus.o_rs2_data !== 64'd0) begin
            failures++; $display("FAIL x0_read: got %h expected 0", bus.o_rs2_data);
        end
        step();
        idle();
        #1;
        checks++;
        if (bus.o_wr_cnt !== cnt0) begin
            failures++; $display("FAIL x0_wr_cnt: got %0d expected %0d", bus.o_wr_cnt, cnt0);
        end
    endtask

    task automatic test_saturate();
        logic [63:0] wd;
        idle();
        bus.i_rs1 = 5'd7;
        for (int k = 0; k < 3; k++) begin
            bus.i_issue_valid = 1'b1;  bus.i_issue_rd = 5'd7;
            #1;
            checks++;
            if (bus.o_issue_ready !== 1'b1) begin
                failures++; $display("FAIL sat_ready_before_%0d: got %b expected 1", k, bus.o_issue_ready);
            end
            step();
        end
        bus.i_issue_valid = 1'b1;  bus.i_issue_rd = 5'd7;
        #1;
        checks++;
        if (bus.o_issue_ready !== 1'b0) begin
            failures++; $display("FAIL sat_ready_full: got %b expected 0", bus.o_issue_ready);
        end
        checks++;
        if (bus.o_rs1_busy !== 1'b1) begin
            failures++; $display("FAIL sat_busy_full: got %b expected 1", bus.o_rs1_busy);
        end
        step();
        for (int k = 0; k < 3; k++) begin
            wd = {$urandom, $urandom};
            bus.i_issue_valid = 1'b0;  bus.i_issue_rd = 5'd7;
            bus.i_rd = 5'd7;  bus.i_rd_wen = 1'b1;  bus.i_rd_wdata = wd;
            #1;
            checks++;
            if (bus.o_rs1_busy !== (k != 2)) begin
                failures++; $display("FAIL sat_drain_busy_%0d: got %b expected %b", k, bus.o_rs1_busy, (k != 2));
            end
            checks++;
            if (bus.o_rs1_data !== wd) begin
                failures++; $display("FAIL sat_drain_data_%0d: got %h expected %h", k, bus.o_rs1_data, wd);
            end
            if (k == 0) begin
                checks++;
                if (bus.o_issue_ready !== 1'b0) begin
                    failures++; $display("FAIL sat_no_lookahead: got %b expected 0", bus.o_issue_ready);
                end
            end
            step();
        end
        idle();
        bus.i_issue_rd = 5'd7;
        #1;
        checks++;
        if (bus.o_rs1_busy !== 1'b0 || bus.o_issue_ready !== 1'b1) begin
            failures++; $display("FAIL sat_drained: got busy=%b ready=%b expected busy=0 ready=1",
                                 bus.o_rs1_busy, bus.o_issue_ready);
        end
    endtask

    task automatic test_issue_wb_same();
        idle();
        bus.i_rs1 = 5'd9;
        bus.i_issue_valid = 1'b1;  bus.i_issue_rd = 5'd9;
        step();
        bus.i_rd = 5'd9;  bus.i_rd_wen = 1'b1;  bus.i_rd_wdata = {$urandom, $urandom};
        #1;
        checks++;
        if (bus.o_rs1_busy !== 1'b0) begin
            failures++; $display("FAIL same_cycle_busy_now: got %b expected 0", bus.o_rs1_busy);
        end
        step();
        idle();
        #1;
        checks++;
        if (bus.o_rs1_busy !== 1'b1) begin
            failures++; $display("FAIL same_cycle_busy_next: got %b expected 1", bus.o_rs1_busy);
        end
        bus.i_rd = 5'd9;  bus.i_rd_wen = 1'b1;  bus.i_rd_wdata = {$urandom, $urandom};
        step();
        idle();
    endtask

    task automatic test_unreserved();
        logic [63:0] wd;
        wd = {$urandom, $urandom};
        idle();
        bus.i_rs2 = 5'd3;
        bus.i_rd = 5'd3;  bus.i_rd_wen = 1'b1;  bus.i_rd_wdata = wd;
        step();
        idle();
        #1;
        checks++;
        if (bus.o_rs2_data !== wd) begin
            failures++; $display("FAIL unres_data: got %h expected %h", bus.o_rs2_data, wd);
        end
        checks++;
        if (bus.o_rs2_busy !== 1'b0) begin
            failures++; $display("FAIL unres_busy: got %b expected 0", bus.o_rs2_busy);
        end
        bus.i_issue_valid = 1'b1;  bus.i_issue_rd = 5'd3;
        step();
        idle();
        #1;
        checks++;
        if (bus.o_rs2_busy !== 1'b1) begin
            failures++; $display("FAIL unres_no_underflow: got %b expected 1", bus.o_rs2_busy);
        end
        bus.i_rd = 5'd3;  bus.i_rd_wen = 1'b1;  bus.i_rd_wdata = {$urandom, $urandom};
        step();
        idle();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rand_inputs();
            #1;
            checks++;
            if (bus.o_rs1_data !== m_data(bus.i_rs1)) begin
                failures++; $display("FAIL rand_rs1_data[%0d]: got %h expected %h", i, bus.o_rs1_data, m_data(bus.i_rs1));
            end
            checks++;
            if (bus.o_rs2_data !== m_data(bus.i_rs2)) begin
                failures++; $display("FAIL rand_rs2_data[%0d]: got %h expected %h", i, bus.o_rs2_data, m_data(bus.i_rs2));
            end
            checks++;
            if (bus.o_rs1_busy !== m_busy(bus.i_rs1) || bus.o_rs2_busy !== m_busy(bus.i_rs2)) begin
                failures++; $display("FAIL rand_busy[%0d]: got %b%b expected %b%b", i,
                                     bus.o_rs1_busy, bus.o_rs2_busy, m_busy(bus.i_rs1), m_busy(bus.i_rs2));
            end
            checks++;
            if (bus.o_issue_ready !== m_ready()) begin
                failures++; $display("FAIL rand_issue_ready[%0d]: got %b expected %b", i, bus.o_issue_ready, m_ready());
            end
            checks++;
            if (bus.o_wr_cnt !== m_cnt) begin
                failures++; $display("FAIL rand_wr_cnt[%0d]: got %0d expected %0d", i, bus.o_wr_cnt, m_cnt);
            end
            step();
        end
        idle();
    endtask

    initial begin
        idle();
        bus.i_rs1 = '0;
        bus.i_rs2 = '0;
        m_clear();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        test_reset();
        test_bypass();
        test_x0();
        test_saturate();
        test_issue_wb_same();
        test_unreserved();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
